// File: rtl/plot_pkg.sv
// rtl/plot_pkg.sv - shared plot constants, arbiter state type and helpers
package plot_pkg;

    localparam int NREQ   = 3;
    localparam int XSZ    = 8;
    localparam int YSZ    = 7;
    localparam int COLSZ  = 3;
    localparam int XMAX   = 160;
    localparam int YMAX   = 120;
    localparam int PCNT_W = 15;

    localparam logic [PCNT_W-1:0] PCNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_TURN
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/plot_arbiter_if.sv
// rtl/plot_arbiter_if.sv - requester-side and vga-side signals of the plot arbiter
interface plot_arbiter_if #(
    parameter int NREQ   = plot_pkg::NREQ,
    parameter int XSZ    = plot_pkg::XSZ,
    parameter int YSZ    = plot_pkg::YSZ,
    parameter int COLSZ  = plot_pkg::COLSZ,
    parameter int PCNT_W = plot_pkg::PCNT_W
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       pix_valid;
    logic [NREQ*XSZ-1:0]   x_in;
    logic [NREQ*YSZ-1:0]   y_in;
    logic [NREQ*COLSZ-1:0] col_in;
    logic [NREQ-1:0]       gnt;
    logic [XSZ-1:0]        x_out;
    logic [YSZ-1:0]        y_out;
    logic [COLSZ-1:0]      col_out;
    logic                  plotEn;
    logic                  busy;
    logic [PCNT_W-1:0]     pix_count;
    logic                  oob_err;

    modport master (
        output req, pix_valid, x_in, y_in, col_in,
        input  gnt, x_out, y_out, col_out, plotEn, busy, pix_count, oob_err
    );

    modport slave (
        input  req, pix_valid, x_in, y_in, col_in,
        output gnt, x_out, y_out, col_out, plotEn, busy, pix_count, oob_err
    );
endinterface

// File: rtl/plot_arbiter_rr_pick.sv
// rtl/plot_arbiter_rr_pick.sv - combinational round-robin picker: first request at or after ptr
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx
);
    logic        found;
    logic [IW:0] pos;

    always_comb begin
        found = 1'b0;
        pos   = '0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // One extra bit so ptr+k never wraps before the modulo fold.
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(NREQ)) begin
                pos = pos - (IW+1)'(NREQ);
            end
            if (!found && req[pos[IW-1:0]]) begin
                found                = 1'b1;
                pick[pos[IW-1:0]]    = 1'b1;
                idx                  = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// rtl/plot_arbiter.sv - round-robin arbiter forwarding one requester's pixels to the vga adapter
module plot_arbiter #(
    parameter int NREQ  = plot_pkg::NREQ,
    parameter int XSZ   = plot_pkg::XSZ,
    parameter int YSZ   = plot_pkg::YSZ,
    parameter int COLSZ = plot_pkg::COLSZ,
    parameter int XMAX  = plot_pkg::XMAX,
    parameter int YMAX  = plot_pkg::YMAX
) (
    input  logic          clk,
    input  logic          resetn,
    plot_arbiter_if.slave bus
);
    import plot_pkg::*;

    localparam int             IW    = idx_w(NREQ);
    localparam logic [XSZ-1:0] X_LIM = XSZ'(XMAX);
    localparam logic [YSZ-1:0] Y_LIM = YSZ'(YMAX);

    arb_state_t        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]     g_q, g_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [XSZ-1:0]    x_out_q, x_out_d;
    logic [YSZ-1:0]    y_out_q, y_out_d;
    logic [COLSZ-1:0]  col_out_q, col_out_d;
    logic              plot_en_q, plot_en_d;
    logic [PCNT_W-1:0] pix_count_q, pix_count_d;
    logic              oob_err_q, oob_err_d;

    logic [NREQ-1:0]   pick;
    logic [IW-1:0]     pick_idx;

    logic              sel_req;
    logic              sel_valid;
    logic [XSZ-1:0]    sel_x;
    logic [YSZ-1:0]    sel_y;
    logic [COLSZ-1:0]  sel_col;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .req  (bus.req),
        .ptr  (rr_ptr_q),
        .pick (pick),
        .idx  (pick_idx)
    );

    // Only the granted requester's lane is ever looked at.
    always_comb begin
        sel_req   = 1'b0;
        sel_valid = 1'b0;
        sel_x     = '0;
        sel_y     = '0;
        sel_col   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g_q == IW'(i)) begin
                sel_req   = bus.req[i];
                sel_valid = bus.pix_valid[i];
                sel_x     = bus.x_in[i*XSZ +: XSZ];
                sel_y     = bus.y_in[i*YSZ +: YSZ];
                sel_col   = bus.col_in[i*COLSZ +: COLSZ];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        g_d         = g_q;
        rr_ptr_d    = rr_ptr_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        col_out_d   = col_out_q;
        plot_en_d   = 1'b0;
        pix_count_d = pix_count_q;
        oob_err_d   = oob_err_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    gnt_d       = pick;
                    g_d         = pick_idx;
                    pix_count_d = '0;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!sel_req) begin
                    // A strobe in the release cycle is dropped with the grant.
                    gnt_d    = '0;
                    state_d  = ST_TURN;
                    rr_ptr_d = (g_q == IW'(NREQ-1)) ? '0 : g_q + IW'(1);
                end else if (sel_valid) begin
                    if (sel_x >= X_LIM || sel_y >= Y_LIM) begin
                        oob_err_d = 1'b1;
                    end else begin
                        x_out_d   = sel_x;
                        y_out_d   = sel_y;
                        col_out_d = sel_col;
                        plot_en_d = 1'b1;
                        if (pix_count_q != PCNT_MAX) begin
                            pix_count_d = pix_count_q + PCNT_W'(1);
                        end
                    end
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            g_q         <= '0;
            rr_ptr_q    <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            col_out_q   <= '0;
            plot_en_q   <= 1'b0;
            pix_count_q <= '0;
            oob_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            g_q         <= g_d;
            rr_ptr_q    <= rr_ptr_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            col_out_q   <= col_out_d;
            plot_en_q   <= plot_en_d;
            pix_count_q <= pix_count_d;
            oob_err_q   <= oob_err_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.x_out     = x_out_q;
    assign bus.y_out     = y_out_q;
    assign bus.col_out   = col_out_q;
    assign bus.plotEn    = plot_en_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.pix_count = pix_count_q;
    assign bus.oob_err   = oob_err_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// tb/tb_plot_arbiter.sv - randomized and directed bench for plot_arbiter against a pixel-level model
module tb_plot_arbiter;

    localparam int N  = 3;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    plot_arbiter_if bus ();

    plot_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who owns the bus, how long the turnaround lasts, what was last plotted.
    int m_owner = -1;
    int m_cool  = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_plot  = 0;
    bit m_oob   = 0;
    int m_x = 0, m_y = 0, m_c = 0;
    int xv, yv, cv, j;

    int plot_pulses = 0;
    int x7_plots    = 0;
    int zero_run    = 0;
    logic [N-1:0] prev_gnt = '0;
    int grant_log[$];
    int gap_log[$];

    always @(posedge clk) begin
        if (!resetn) begin
            m_owner = -1; m_cool = 0; m_ptr = 0; m_cnt = 0;
            m_plot = 0; m_oob = 0; m_x = 0; m_y = 0; m_c = 0;
        end else begin
            m_plot = 0;
            if (m_owner < 0) begin
                if (m_cool > 0) begin
                    m_cool--;
                end else if (bus.req != 0) begin
                    for (int k = 0; k < N; k++) begin
                        j = (m_ptr + k) % N;
                        if (bus.req[j]) begin
                            m_owner = j;
                            break;
                        end
                    end
                    m_cnt = 0;
                end
            end else if (!bus.req[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_cool  = 1;
            end else if (bus.pix_valid[m_owner]) begin
                xv = int'(bus.x_in[m_owner*XW +: XW]);
                yv = int'(bus.y_in[m_owner*YW +: YW]);
                cv = int'(bus.col_in[m_owner*CW +: CW]);
                if (xv < 160 && yv < 120) begin
                    m_x = xv; m_y = yv; m_c = cv;
                    m_plot = 1;
                    m_cnt = (m_cnt < 32767) ? m_cnt + 1 : 32767;
                end else begin
                    m_oob = 1;
                end
            end
        end
        #1;
        chk("gnt", bus.gnt, (m_owner >= 0) ? (1 << m_owner) : 0);
        chk("plotEn", bus.plotEn, m_plot);
        chk("busy", bus.busy, (m_owner >= 0 || m_cool > 0));
        chk("pix_count", bus.pix_count, m_cnt);
        chk("oob_err", bus.oob_err, m_oob);
        chk("x_out", bus.x_out, m_x);
        chk("y_out", bus.y_out, m_y);
        chk("col_out", bus.col_out, m_c);
        if (bus.plotEn) plot_pulses++;
        if (bus.plotEn && bus.x_out == 7) x7_plots++;
        if (bus.gnt != 0 && prev_gnt == 0) begin
            for (int k = 0; k < N; k++) if (bus.gnt[k]) grant_log.push_back(k);
            gap_log.push_back(zero_run);
        end
        zero_run = (bus.gnt == 0) ? zero_run + 1 : 0;
        prev_gnt = bus.gnt;
    end

    task automatic set_pix(input int i, input bit v, input int x, input int y, input int c);
        bus.pix_valid[i]         = v;
        bus.x_in[i*XW +: XW]     = XW'(x);
        bus.y_in[i*YW +: YW]     = YW'(y);
        bus.col_in[i*CW +: CW]   = CW'(c);
    endtask

    task automatic wait_gnt(input int i, output bit ok);
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.gnt[i]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("gnt_timeout", 0, 1);
    endtask

    task automatic wait_any(output int g);
        g = -1;
        for (int t = 0; t < 20 && g < 0; t++) begin
            if (bus.gnt != 0) begin
                for (int k = 0; k < N; k++) if (bus.gnt[k]) g = k;
            end else begin
                @(negedge clk);
            end
        end
        if (g < 0) chk("any_gnt_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        bus.req = '0; bus.pix_valid = '0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int left[N];

    initial begin
        bit ok;
        int g, p0, x0, l0;
        bus.req = '0; bus.pix_valid = '0;
        bus.x_in = '0; bus.y_in = '0; bus.col_in = '0;

        // Reset state
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_plotEn", bus.plotEn, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pix_count", bus.pix_count, 0);
        chk("rst_oob", bus.oob_err, 0);
        chk("rst_x_out", bus.x_out, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Single requester burst
        @(negedge clk);
        bus.req = 3'b010;
        p0 = plot_pulses;
        @(posedge clk); #2;
        chk("t1_gnt_latency", bus.gnt, 3'b010);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_pix(1, 1, 10 + k, 20, 4);
        end
        @(negedge clk);
        set_pix(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("t1_pix_count", bus.pix_count, 4);
        chk("t1_pulses", plot_pulses - p0, 4);
        chk("t1_x_last", bus.x_out, 13);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // All three requesting from reset
        do_reset();
        l0 = grant_log.size();
        bus.req = 3'b111;
        @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            wait_any(g);
            if (g < 0) break;
            set_pix(g, 1, 30 + g, 2, g);
            @(negedge clk);
            set_pix(g, 0, 0, 0, 0);
            bus.req[g] = 1'b0;
            @(negedge clk);
            if (n == 0) bus.req[0] = 1'b1;
        end
        bus.req = '0;
        repeat (3) @(negedge clk);
        chk("t2_grants", grant_log.size() - l0, 4);
        if (grant_log.size() - l0 == 4) begin
            chk("t2_order0", grant_log[l0], 0);
            chk("t2_order1", grant_log[l0+1], 1);
            chk("t2_order2", grant_log[l0+2], 2);
            chk("t2_order3", grant_log[l0+3], 0);
            for (int k = 1; k < 4; k++) chk("t2_gap", gap_log[l0+k], 2);
        end

        // Out-of-frame pixels
        chk("t3_oob_before", bus.oob_err, 0);
        p0 = plot_pulses;
        bus.req = 3'b100;
        wait_gnt(2, ok);
        set_pix(2, 1, 160, 5, 1);
        @(negedge clk);
        set_pix(2, 1, 5, 120, 2);
        @(negedge clk);
        set_pix(2, 1, 159, 119, 3);
        @(negedge clk);
        set_pix(2, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_oob", bus.oob_err, 1);
        chk("t3_pix_count", bus.pix_count, 1);
        chk("t3_pulses", plot_pulses - p0, 1);
        chk("t3_x", bus.x_out, 159);
        chk("t3_y", bus.y_out, 119);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Interference from a non-granted requester
        do_reset();
        chk("t4_oob_cleared", bus.oob_err, 0);
        x0 = x7_plots;
        bus.req = 3'b001;
        wait_gnt(0, ok);
        for (int k = 0; k < 4; k++) begin
            set_pix(0, 1, 20 + k, 9, 5);
            set_pix(2, (k % 2) == 0, 7, 3, 6);
            @(negedge clk);
        end
        set_pix(0, 0, 0, 0, 0);
        set_pix(2, 0, 0, 0, 0);
        @(negedge clk);
        chk("t4_no_x7", x7_plots - x0, 0);
        chk("t4_pix_count", bus.pix_count, 4);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Reset in the middle of a burst
        bus.req = 3'b010;
        wait_gnt(1, ok);
        set_pix(1, 1, 50, 60, 5);
        @(negedge clk);
        set_pix(1, 0, 0, 0, 0);
        resetn = 1'b0;
        bus.req = '0;
        #1;
        chk("t5_plotEn", bus.plotEn, 0);
        chk("t5_x", bus.x_out, 0);
        chk("t5_y", bus.y_out, 0);
        chk("t5_col", bus.col_out, 0);
        chk("t5_gnt", bus.gnt, 0);
        chk("t5_busy", bus.busy, 0);
        @(negedge clk);
        chk("t5_plotEn_held", bus.plotEn, 0);
        resetn = 1'b1;
        bus.req = 3'b100;
        @(posedge clk); #2;
        chk("t5_regrant", bus.gnt, 3'b100);
        @(negedge clk);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Counter saturation
        p0 = plot_pulses;
        bus.req = 3'b001;
        wait_gnt(0, ok);
        for (int n = 0; n < 32800; n++) begin
            set_pix(0, 1, n % 160, (n / 160) % 120, n % 8);
            @(negedge clk);
        end
        set_pix(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t6_pix_count_sat", bus.pix_count, 32767);
        chk("t6_pulses", plot_pulses - p0, 32800);
        bus.req = '0;
        repeat (3) @(negedge clk);

        // Randomized traffic with occasional resets
        for (int i = 0; i < N; i++) left[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i]) begin
                    if ($urandom_range(0, 5) == 0) begin
                        bus.req[i] = 1'b1;
                        left[i] = int'($urandom_range(0, 8));
                    end
                end else if (bus.gnt[i]) begin
                    if (left[i] == 0) bus.req[i] = 1'b0;
                    else left[i]--;
                end
                set_pix(i, $urandom_range(0, 1) == 1, int'($urandom_range(0, 175)),
                        int'($urandom_range(0, 127)), int'($urandom_range(0, 7)));
            end
            resetn = ($urandom_range(0, 499) != 0);
        end
        @(negedge clk);
        resetn = 1'b1;
        bus.req = '0; bus.pix_valid = '0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
